// File: rtl/inst_execute_if.sv
// inst_execute_if: bundles the decode-side operand fields, the req/ack memory
// port and the writeback port of the execute stage.
//   master : driver side (decode stage / memory model / testbench)
//   slave  : execute stage (inst_execute)
// Decode side  : id_valid, rd, funct3, funct7, op1, op2, imm_flag, mem_acc,
//                load_flag, write_back
// Memory port  : mem_req, mem_addr (out of stage); mem_ack, mem_rdata (in)
// Writeback    : wb_en, wb_rd, wb_value; status busy, exc_err
interface inst_execute_if #(
   parameter int XLEN = 64
);
   logic            id_valid;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            imm_flag;
   logic            mem_acc;
   logic            load_flag;
   logic            write_back;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;
   logic            busy;
   logic            mem_req;
   logic [XLEN-1:0] mem_addr;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_value;
   logic            exc_err;

   modport master (
      output id_valid, rd, funct3, funct7, op1, op2, imm_flag, mem_acc,
             load_flag, write_back, mem_ack, mem_rdata,
      input  busy, mem_req, mem_addr, wb_en, wb_rd, wb_value, exc_err
   );

   modport slave (
      input  id_valid, rd, funct3, funct7, op1, op2, imm_flag, mem_acc,
             load_flag, write_back, mem_ack, mem_rdata,
      output busy, mem_req, mem_addr, wb_en, wb_rd, wb_value, exc_err
   );
endinterface

// File: rtl/inst_execute.sv
// inst_execute: execute stage behind instruction decode. Single-cycle integer
// ALU ops, 64-bit loads over a req/ack memory port with timeout, and an
// optional shift-add multiplier (build macro EXEC_MUL_EN).
// Ports:
//   CLK    clock, all logic on posedge
//   reset  synchronous active-high reset
//   bus    inst_execute_if.slave (decode fields in, memory port, writeback out)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | accepting ops; ALU results written back one cycle later
// ST_MEM   | load outstanding, mem_req held, timeout timer running
// ST_MUL   | shift-add multiply in progress (EXEC_MUL_EN builds only)
module inst_execute #(
   parameter int XLEN        = 64,
   parameter int MEM_TIMEOUT = 255
) (
   input logic           CLK,
   input logic           reset,
   inst_execute_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MEM  = 2'd1;
`ifdef EXEC_MUL_EN
   localparam logic [1:0] ST_MUL  = 2'd2;
`endif

   logic [1:0]      state;
   logic [7:0]      mem_tmr;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] alu_result;
   logic [5:0]      shamt;
   logic            sub_sel;
   logic            sra_sel;

   assign shamt   = bus.op2[5:0];
   assign sub_sel = !bus.imm_flag && bus.funct7[5];
   // For immediates the arithmetic-shift flag lives in imm bit 10.
   assign sra_sel = bus.imm_flag ? bus.op2[10] : bus.funct7[5];

   // funct7 bits outside [5] only matter to the multiplier decode.
   logic unused_funct7;
   assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

   always_comb begin
      alu_result = '0;
      case (bus.funct3)
         3'b000: alu_result = sub_sel ? (bus.op1 - bus.op2) : (bus.op1 + bus.op2);
         3'b001: alu_result = bus.op1 << shamt;
         3'b010: alu_result = {{(XLEN-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
         3'b011: alu_result = {{(XLEN-1){1'b0}}, (bus.op1 < bus.op2)};
         3'b100: alu_result = bus.op1 ^ bus.op2;
         3'b101: alu_result = sra_sel ? $unsigned($signed(bus.op1) >>> shamt)
                                      : (bus.op1 >> shamt);
         3'b110: alu_result = bus.op1 | bus.op2;
         3'b111: alu_result = bus.op1 & bus.op2;
         default: alu_result = '0;
      endcase
   end

`ifdef EXEC_MUL_EN
   logic [XLEN-1:0] mul_mcand;
   logic [XLEN-1:0] mul_mplier;
   logic [XLEN-1:0] mul_acc;
   logic [XLEN-1:0] mul_acc_next;
   logic [6:0]      mul_cnt;
   logic            mul_wb;
   logic            is_mul;

   assign is_mul       = !bus.imm_flag && (bus.funct7 == 7'b0000001) && (bus.funct3 == 3'b000);
   assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

   assign bus.busy = (state != ST_IDLE);

   always_ff @(posedge CLK) begin
      if (reset) begin
         state        <= ST_IDLE;
         mem_tmr      <= '0;
         rd_q         <= '0;
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
         bus.wb_en    <= 1'b0;
         bus.wb_rd    <= '0;
         bus.wb_value <= '0;
         bus.exc_err  <= 1'b0;
`ifdef EXEC_MUL_EN
         mul_mcand    <= '0;
         mul_mplier   <= '0;
         mul_acc      <= '0;
         mul_cnt      <= '0;
         mul_wb       <= 1'b0;
`endif
      end else begin
         bus.wb_en   <= 1'b0;
         bus.exc_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.id_valid) begin
                  if (!bus.mem_acc) begin
`ifdef EXEC_MUL_EN
                     if (is_mul) begin
                        mul_mcand  <= bus.op1;
                        mul_mplier <= bus.op2;
                        mul_acc    <= '0;
                        mul_cnt    <= 7'd64;
                        mul_wb     <= bus.write_back && (bus.rd != 5'd0);
                        rd_q       <= bus.rd;
                        state      <= ST_MUL;
                     end else
`endif
                     if (bus.write_back && (bus.rd != 5'd0)) begin
                        bus.wb_en    <= 1'b1;
                        bus.wb_rd    <= bus.rd;
                        bus.wb_value <= alu_result;
                     end
                  end else if (bus.load_flag) begin
                     bus.mem_req  <= 1'b1;
                     bus.mem_addr <= bus.op1 + bus.op2;
                     rd_q         <= bus.rd;
                     mem_tmr      <= 8'(MEM_TIMEOUT);
                     state        <= ST_MEM;
                  end
                  // stores are unsupported and retire silently
               end
            end
            ST_MEM: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  if (rd_q != 5'd0) begin
                     bus.wb_en    <= 1'b1;
                     bus.wb_rd    <= rd_q;
                     bus.wb_value <= bus.mem_rdata;
                  end
                  state <= ST_IDLE;
               end else if (mem_tmr <= 8'd1) begin
                  bus.mem_req <= 1'b0;
                  bus.exc_err <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  mem_tmr <= mem_tmr - 8'd1;
               end
            end
`ifdef EXEC_MUL_EN
            ST_MUL: begin
               mul_acc    <= mul_acc_next;
               mul_mcand  <= mul_mcand << 1;
               mul_mplier <= mul_mplier >> 1;
               if (mul_cnt == 7'd1) begin
                  if (mul_wb) begin
                     bus.wb_en    <= 1'b1;
                     bus.wb_rd    <= rd_q;
                     bus.wb_value <= mul_acc_next;
                  end
                  state <= ST_IDLE;
               end else begin
                  mul_cnt <= mul_cnt - 7'd1;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_execute.sv
module tb_inst_execute;
   logic CLK = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 CLK = ~CLK;

   inst_execute_if #(.XLEN(64)) bus ();

   inst_execute #(.XLEN(64), .MEM_TIMEOUT(255)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        imm;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic [63:0] exp;
   } alu_vec_t;

   alu_vec_t vecs[$];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.id_valid   = 1'b0;
      bus.rd         = '0;
      bus.funct3     = '0;
      bus.funct7     = '0;
      bus.op1        = '0;
      bus.op2        = '0;
      bus.imm_flag   = 1'b0;
      bus.mem_acc    = 1'b0;
      bus.load_flag  = 1'b0;
      bus.write_back = 1'b0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = '0;
   endtask

   task automatic drive_op(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                           input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                           input logic wb, input logic macc, input logic ld);
      bus.id_valid   = 1'b1;
      bus.funct3     = f3;
      bus.funct7     = f7;
      bus.imm_flag   = imm;
      bus.op1        = a;
      bus.op2        = b;
      bus.rd         = rd;
      bus.write_back = wb;
      bus.mem_acc    = macc;
      bus.load_flag  = ld;
   endtask

   task automatic add_vec(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp);
      alu_vec_t v;
      v.f3 = f3; v.f7 = f7; v.imm = imm; v.a = a; v.b = b; v.rd = rd; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({bus.busy, bus.mem_req, bus.wb_en, bus.exc_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got busy/req/wb/exc=%b expected 0000",
                  {bus.busy, bus.mem_req, bus.wb_en, bus.exc_err});
      end
      checks++;
      if (bus.mem_addr !== 64'd0 || bus.wb_value !== 64'd0 || bus.wb_rd !== 5'd0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h val=%h rd=%0d expected all 0",
                  bus.mem_addr, bus.wb_value, bus.wb_rd);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_alu();
      vecs.delete();
      add_vec(3'b000, 7'h00, 1'b0, 64'd5, 64'd7, 5'd3, 64'd12);
      add_vec(3'b000, 7'h20, 1'b0, 64'd0, 64'd1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
      add_vec(3'b000, 7'h20, 1'b1, 64'd10, 64'd3, 5'd5, 64'd13);
      add_vec(3'b101, 7'h00, 1'b1, 64'h8000_0000_0000_0000, 64'h401, 5'd6, 64'hC000_0000_0000_0000);
      add_vec(3'b101, 7'h00, 1'b1, 64'h8000_0000_0000_0000, 64'h001, 5'd7, 64'h4000_0000_0000_0000);
      add_vec(3'b101, 7'h20, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd8, 64'hF800_0000_0000_0000);
      add_vec(3'b001, 7'h00, 1'b0, 64'd1, 64'h43, 5'd9, 64'd8);
      add_vec(3'b010, 7'h00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd10, 64'd1);
      add_vec(3'b011, 7'h00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd11, 64'd0);
      add_vec(3'b100, 7'h00, 1'b0, 64'hF0, 64'hFF, 5'd12, 64'h0F);
      add_vec(3'b110, 7'h00, 1'b0, 64'hF0, 64'h0F, 5'd13, 64'hFF);
      add_vec(3'b111, 7'h00, 1'b0, 64'hF0, 64'h3C, 5'd14, 64'h30);
      add_vec(3'b000, 7'h00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd15, 64'd1);
`ifndef EXEC_MUL_EN
      add_vec(3'b000, 7'h01, 1'b0, 64'd3, 64'd5, 5'd16, 64'd8);
`endif
      foreach (vecs[i]) begin
         drive_op(vecs[i].f3, vecs[i].f7, vecs[i].imm, vecs[i].a, vecs[i].b,
                  vecs[i].rd, 1'b1, 1'b0, 1'b0);
         step();
         bus.id_valid = 1'b0;
         checks++;
         if (bus.wb_en !== 1'b1 || bus.wb_rd !== vecs[i].rd || bus.wb_value !== vecs[i].exp) begin
            errors++;
            $display("FAIL alu_vec%0d: got wb_en=%b rd=%0d val=%h expected 1 rd=%0d val=%h",
                     i, bus.wb_en, bus.wb_rd, bus.wb_value, vecs[i].rd, vecs[i].exp);
         end
         step();
         checks++;
         if (bus.wb_en !== 1'b0) begin
            errors++;
            $display("FAIL alu_pulse%0d: got wb_en=%b expected 0", i, bus.wb_en);
         end
      end
   endtask

   task automatic test_no_wb();
      // last vector left wb_rd/wb_value at a known pair
      drive_op(3'b000, 7'h00, 1'b0, 64'd100, 64'd1, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      bus.id_valid = 1'b0;
      checks++;
      if (bus.wb_en !== 1'b0 || bus.wb_value === 64'd101) begin
         errors++;
         $display("FAIL rd_zero: got wb_en=%b val=%h expected 0 and held value", bus.wb_en, bus.wb_value);
      end
      drive_op(3'b000, 7'h00, 1'b0, 64'd200, 64'd1, 5'd2, 1'b0, 1'b0, 1'b0);
      step();
      bus.id_valid = 1'b0;
      checks++;
      if (bus.wb_en !== 1'b0 || bus.wb_rd === 5'd2 || bus.wb_value === 64'd201) begin
         errors++;
         $display("FAIL no_write_back: got wb_en=%b rd=%0d val=%h expected 0, held rd/val",
                  bus.wb_en, bus.wb_rd, bus.wb_value);
      end
      drive_op(3'b000, 7'h00, 1'b0, 64'd1, 64'd2, 5'd3, 1'b1, 1'b1, 1'b0);
      step();
      bus.id_valid = 1'b0;
      checks++;
      if ({bus.wb_en, bus.mem_req, bus.busy} !== 3'b000) begin
         errors++;
         $display("FAIL store_nop: got wb/req/busy=%b expected 000", {bus.wb_en, bus.mem_req, bus.busy});
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_v [3];
      exp_v[0] = 64'd3; exp_v[1] = 64'd30; exp_v[2] = 64'd300;
      for (int k = 0; k < 3; k++) begin
         drive_op(3'b000, 7'h00, 1'b0, exp_v[k] - 64'd1, 64'd1, 5'(k + 20), 1'b1, 1'b0, 1'b0);
         step();
         checks++;
         if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'(k + 20) || bus.wb_value !== exp_v[k]) begin
            errors++;
            $display("FAIL b2b%0d: got wb_en=%b rd=%0d val=%h expected 1 rd=%0d val=%h",
                     k, bus.wb_en, bus.wb_rd, bus.wb_value, k + 20, exp_v[k]);
         end
      end
      bus.id_valid = 1'b0;
      step();
   endtask

   task automatic test_load();
      drive_op(3'b011, 7'h00, 1'b1, 64'h100, 64'h8, 5'd7, 1'b1, 1'b1, 1'b1);
      step();
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h108 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL load_issue: got req=%b addr=%h busy=%b expected 1 108 1",
                  bus.mem_req, bus.mem_addr, bus.busy);
      end
      // an ALU op presented during the wait must be ignored
      drive_op(3'b000, 7'h00, 1'b0, 64'd1, 64'd1, 5'd9, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if (bus.wb_en !== 1'b0 || bus.busy !== 1'b1 || bus.mem_addr !== 64'h108) begin
            errors++;
            $display("FAIL load_wait%0d: got wb_en=%b busy=%b addr=%h expected 0 1 108",
                     k, bus.wb_en, bus.busy, bus.mem_addr);
         end
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 64'hDEAD;
      step();
      bus.mem_ack  = 1'b0;
      bus.id_valid = 1'b0;
      checks++;
      if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_value !== 64'hDEAD ||
          bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL load_done: got wb_en=%b rd=%0d val=%h req=%b busy=%b expected 1 7 dead 0 0",
                  bus.wb_en, bus.wb_rd, bus.wb_value, bus.mem_req, bus.busy);
      end
      step();
      checks++;
      if (bus.wb_en !== 1'b0) begin
         errors++;
         $display("FAIL load_pulse: got wb_en=%b expected 0", bus.wb_en);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 64'h1234;
      step();
      bus.mem_ack = 1'b0;
      checks++;
      if (bus.wb_en !== 1'b0 || bus.wb_value !== 64'hDEAD) begin
         errors++;
         $display("FAIL stray_ack: got wb_en=%b val=%h expected 0 dead", bus.wb_en, bus.wb_value);
      end
   endtask

   task automatic test_timeout();
      int  n = 0;
      bit  saw_wb = 1'b0;
      drive_op(3'b000, 7'h00, 1'b1, 64'h200, 64'h0, 5'd8, 1'b1, 1'b1, 1'b1);
      step();
      bus.id_valid = 1'b0;
      while (bus.mem_req === 1'b1 && n < 400) begin
         step();
         n++;
         if (bus.wb_en === 1'b1) saw_wb = 1'b1;
      end
      checks++;
      if (n !== 255) begin
         errors++;
         $display("FAIL timeout_len: got %0d cycles of mem_req expected 255", n);
      end
      checks++;
      if (bus.exc_err !== 1'b1 || saw_wb !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_exc: got exc=%b saw_wb=%b busy=%b expected 1 0 0",
                  bus.exc_err, saw_wb, bus.busy);
      end
      step();
      checks++;
      if (bus.exc_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: got exc_err=%b expected 0", bus.exc_err);
      end
   endtask

   task automatic test_reset_mid_load();
      drive_op(3'b000, 7'h00, 1'b1, 64'h300, 64'h4, 5'd9, 1'b1, 1'b1, 1'b1);
      step();
      bus.id_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({bus.busy, bus.mem_req, bus.wb_en, bus.exc_err} !== 4'b0000 ||
          bus.mem_addr !== 64'd0 || bus.wb_value !== 64'd0 || bus.wb_rd !== 5'd0) begin
         errors++;
         $display("FAIL reset_mid: got busy/req/wb/exc=%b addr=%h val=%h rd=%0d expected all 0",
                  {bus.busy, bus.mem_req, bus.wb_en, bus.exc_err}, bus.mem_addr, bus.wb_value, bus.wb_rd);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 64'hBEEF;
      step();
      bus.mem_ack = 1'b0;
      checks++;
      if (bus.wb_en !== 1'b0 || bus.wb_value !== 64'd0 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL late_ack: got wb_en=%b val=%h req=%b expected 0 0 0",
                  bus.wb_en, bus.wb_value, bus.mem_req);
      end
   endtask

`ifdef EXEC_MUL_EN
   task automatic test_mul();
      int n = 0;
      drive_op(3'b000, 7'h01, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd5, 1'b1, 1'b0, 1'b0);
      step();
      bus.id_valid = 1'b0;
      while (bus.busy === 1'b1 && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (n !== 64 || bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd5 ||
          bus.wb_value !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         errors++;
         $display("FAIL mul: got cycles=%0d wb_en=%b rd=%0d val=%h expected 64 1 5 fffffffffffffffa",
                  n, bus.wb_en, bus.wb_rd, bus.wb_value);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_no_wb();
      test_back_to_back();
      test_load();
      test_timeout();
      test_reset_mid_load();
`ifdef EXEC_MUL_EN
      test_mul();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
